// File: rtl/tdp_ram_clr.sv
`default_nettype none
// ============================================================================
// Module   : tdp_ram_clr
// Purpose  : True-dual-port synchronous RAM with byte enables, read-valid
//            strobes, deterministic same-address merge and reset-time clear.
// Revision : 1.0
// ============================================================================
module tdp_ram_clr #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 8,
    parameter int                INIT_CLEAR = 1,
    parameter logic [DATA_W-1:0] CLR_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [DATA_W/8-1:0]   be_a,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [DATA_W-1:0]     data_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [DATA_W/8-1:0]   be_b,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [DATA_W-1:0]     data_b,
    output logic [DATA_W-1:0]     q_a,
    output logic [DATA_W-1:0]     q_b,
    output logic                  valid_a,
    output logic                  valid_b,
    output logic                  busy,
    output logic                  collision
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = (INIT_CLEAR != 0) ? S_CLEAR : S_READY;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   q_a_q, q_a_d, q_b_q, q_b_d;
    logic                valid_a_q, valid_a_d, valid_b_q, valid_b_d;
    logic                coll_q, coll_d;

    logic                w_ready;
    logic                w_acc_a, w_acc_b, w_wr_a, w_wr_b, w_both_wr;
    logic [DATA_W-1:0]   w_old_a, w_old_b;
    logic [DATA_W-1:0]   w_mrg_a, w_mrg_b, w_mrg_ab;
    logic [DATA_W-1:0]   w_wdata_a, w_wdata_b;

    assign w_ready   = (state_q == S_READY);
    assign w_acc_a   = w_ready & en_a;
    assign w_acc_b   = w_ready & en_b;
    assign w_wr_a    = w_acc_a & we_a;
    assign w_wr_b    = w_acc_b & we_b;
    assign w_both_wr = w_wr_a & w_wr_b & (addr_a == addr_b);

    assign w_old_a = mem[addr_a];
    assign w_old_b = mem[addr_b];

    // Same-address double write: port A owns any byte both ports enable.
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign w_mrg_a[8*i +: 8]  = be_a[i] ? data_a[8*i +: 8] : w_old_a[8*i +: 8];
        assign w_mrg_b[8*i +: 8]  = be_b[i] ? data_b[8*i +: 8] : w_old_b[8*i +: 8];
        assign w_mrg_ab[8*i +: 8] = be_a[i] ? data_a[8*i +: 8] :
                                    be_b[i] ? data_b[8*i +: 8] : w_old_a[8*i +: 8];
    end

    assign w_wdata_a = w_both_wr ? w_mrg_ab : w_mrg_a;
    assign w_wdata_b = w_both_wr ? w_mrg_ab : w_mrg_b;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        q_a_d     = q_a_q;
        q_b_d     = q_b_q;
        valid_a_d = 1'b0;
        valid_b_d = 1'b0;
        coll_d    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d = S_READY;
                end
            end
            default: begin
                if (w_acc_a) begin
                    q_a_d     = we_a ? w_wdata_a : w_old_a;
                    valid_a_d = 1'b1;
                end
                if (w_acc_b) begin
                    q_b_d     = we_b ? w_wdata_b : w_old_b;
                    valid_b_d = 1'b1;
                end
                coll_d = w_both_wr & (|(be_a & be_b));
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
            q_a_q     <= '0;
            q_b_q     <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            q_a_q     <= q_a_d;
            q_b_q     <= q_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
            coll_q    <= coll_d;
        end
    end

    // The array has no reset; the sweep is the only way to give it known contents.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[clr_cnt_q] <= CLR_VALUE;
        end else begin
            if (w_wr_a) begin
                mem[addr_a] <= w_wdata_a;
            end
            if (w_wr_b && !w_both_wr) begin
                mem[addr_b] <= w_wdata_b;
            end
        end
    end

    assign q_a       = q_a_q;
    assign q_b       = q_b_q;
    assign valid_a   = valid_a_q;
    assign valid_b   = valid_b_q;
    assign busy      = (state_q == S_CLEAR);
    assign collision = coll_q;

endmodule
`default_nettype wire

// File: tb/tb_tdp_ram_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdp_ram_clr
// Purpose  : Self-checking bench for tdp_ram_clr (clear sweep, byte enables,
//            same-address merge/collision, read-first, reset, INIT_CLEAR=0).
// Revision : 1.0
// ============================================================================
module tb_tdp_ram_clr;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, we_a, en_b, we_b;
    logic [3:0]  be_a, be_b;
    logic [7:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic [31:0] q_a, q_b;
    logic        valid_a, valid_b, busy, collision;

    logic        n_rst;
    logic        n_en_a, n_we_a;
    logic [3:0]  n_be_a;
    logic [7:0]  n_addr_a;
    logic [31:0] n_data_a;
    logic [31:0] n_q_a, n_q_b;
    logic        n_valid_a, n_valid_b, n_busy, n_collision;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_qa [$];
    logic [31:0] exp_qb [$];

    typedef struct {
        logic        en_a;
        logic        we_a;
        logic [3:0]  be_a;
        logic [7:0]  addr_a;
        logic [31:0] data_a;
        logic        en_b;
        logic        we_b;
        logic [3:0]  be_b;
        logic [7:0]  addr_b;
        logic [31:0] data_b;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        col;
    } vec_t;

    vec_t vt [18];
    vec_t vp [3];

    always #5 clk = ~clk;

    tdp_ram_clr #(.DATA_W(32), .ADDR_W(8), .INIT_CLEAR(1), .CLR_VALUE(32'h0)) dut (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
        .q_a(q_a), .q_b(q_b), .valid_a(valid_a), .valid_b(valid_b),
        .busy(busy), .collision(collision)
    );

    tdp_ram_clr #(.DATA_W(32), .ADDR_W(8), .INIT_CLEAR(0), .CLR_VALUE(32'h0)) dut_nc (
        .clk(clk), .rst(n_rst),
        .en_a(n_en_a), .we_a(n_we_a), .be_a(n_be_a), .addr_a(n_addr_a), .data_a(n_data_a),
        .en_b(1'b0), .we_b(1'b0), .be_b(4'h0), .addr_b(8'h00), .data_b(32'h0),
        .q_a(n_q_a), .q_b(n_q_b), .valid_a(n_valid_a), .valid_b(n_valid_b),
        .busy(n_busy), .collision(n_collision)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of traffic, queue expectations, compare after the edge.
    task automatic step(input vec_t v, input int idx);
        en_a = v.en_a; we_a = v.we_a; be_a = v.be_a; addr_a = v.addr_a; data_a = v.data_a;
        en_b = v.en_b; we_b = v.we_b; be_b = v.be_b; addr_b = v.addr_b; data_b = v.data_b;
        if (v.en_a) exp_qa.push_back(v.exp_a);
        if (v.en_b) exp_qb.push_back(v.exp_b);
        @(posedge clk); #1;
        chk($sformatf("v%0d valid_a", idx), {31'd0, valid_a}, {31'd0, v.en_a});
        chk($sformatf("v%0d valid_b", idx), {31'd0, valid_b}, {31'd0, v.en_b});
        chk($sformatf("v%0d collision", idx), {31'd0, collision}, {31'd0, v.col});
        if (valid_a) begin
            if (exp_qa.size() == 0) chk($sformatf("v%0d unexpected q_a", idx), 32'd1, 32'd0);
            else chk($sformatf("v%0d q_a", idx), q_a, exp_qa.pop_front());
        end else if (exp_qa.size() != 0) begin
            void'(exp_qa.pop_front());
        end
        if (valid_b) begin
            if (exp_qb.size() == 0) chk($sformatf("v%0d unexpected q_b", idx), 32'd1, 32'd0);
            else chk($sformatf("v%0d q_b", idx), q_b, exp_qb.pop_front());
        end else if (exp_qb.size() != 0) begin
            void'(exp_qb.pop_front());
        end
    endtask

    // Count edges from release until busy drops; also count stray valid pulses.
    task automatic sweep(input string nm);
        int fall = -1;
        int vcnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (valid_a || valid_b) vcnt++;
            if (!busy) begin
                fall = k;
                break;
            end
        end
        chk({nm, " busy fall edge"}, fall, 32'd255);
        chk({nm, " valid during clear"}, vcnt, 32'd0);
    endtask

    initial begin
        vt[0]  = '{1,0,4'h0,8'h00,32'h0,        1,0,4'h0,8'h7F,32'h0,        32'h0,        32'h0,        0};
        vt[1]  = '{1,0,4'h0,8'hFF,32'h0,        0,0,4'h0,8'h00,32'h0,        32'h0,        32'h0,        0};
        vt[2]  = '{1,1,4'hF,8'h05,32'hAABBCCDD, 0,0,4'h0,8'h00,32'h0,        32'hAABBCCDD, 32'h0,        0};
        vt[3]  = '{1,1,4'h5,8'h05,32'h11223344, 0,0,4'h0,8'h00,32'h0,        32'hAA22CC44, 32'h0,        0};
        vt[4]  = '{0,0,4'h0,8'h00,32'h0,        1,0,4'h0,8'h05,32'h0,        32'h0,        32'hAA22CC44, 0};
        vt[5]  = '{1,1,4'h3,8'h09,32'h11111111, 1,1,4'h6,8'h09,32'h22222222, 32'h00221111, 32'h00221111, 1};
        vt[6]  = '{1,0,4'h0,8'h09,32'h0,        0,0,4'h0,8'h00,32'h0,        32'h00221111, 32'h0,        0};
        vt[7]  = '{1,1,4'hF,8'h03,32'h5,        0,0,4'h0,8'h00,32'h0,        32'h5,        32'h0,        0};
        vt[8]  = '{1,1,4'hF,8'h03,32'h6,        1,0,4'h0,8'h03,32'h0,        32'h6,        32'h5,        0};
        vt[9]  = '{1,0,4'h0,8'h03,32'h0,        0,0,4'h0,8'h00,32'h0,        32'h6,        32'h0,        0};
        vt[10] = '{1,1,4'h0,8'h05,32'hFFFFFFFF, 0,0,4'h0,8'h00,32'h0,        32'hAA22CC44, 32'h0,        0};
        vt[11] = '{1,0,4'h0,8'hFF,32'h0,        1,1,4'hF,8'hFF,32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0};
        vt[12] = '{1,0,4'h0,8'hFF,32'h0,        1,0,4'h0,8'hFF,32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0};
        vt[13] = '{1,1,4'hF,8'h10,32'h01020304, 1,1,4'hF,8'h11,32'hA0B0C0D0, 32'h01020304, 32'hA0B0C0D0, 0};
        vt[14] = '{1,0,4'h0,8'h11,32'h0,        1,0,4'h0,8'h10,32'h0,        32'hA0B0C0D0, 32'h01020304, 0};
        vt[15] = '{1,1,4'hC,8'h20,32'hAABB0000, 1,1,4'h3,8'h20,32'h0000CCDD, 32'hAABBCCDD, 32'hAABBCCDD, 0};
        vt[16] = '{1,1,4'hF,8'h21,32'h12345678, 1,1,4'hF,8'h21,32'h87654321, 32'h12345678, 32'h12345678, 1};
        vt[17] = '{0,0,4'h0,8'h21,32'h0,        0,0,4'h0,8'h21,32'h0,        32'h0,        32'h0,        0};

        vp[0]  = '{1,0,4'h0,8'h05,32'h0,        1,0,4'h0,8'hFF,32'h0,        32'h0,        32'h0,        0};
        vp[1]  = '{1,0,4'h0,8'h21,32'h0,        1,0,4'h0,8'h09,32'h0,        32'h0,        32'h0,        0};
        vp[2]  = '{1,0,4'h0,8'h20,32'h0,        0,0,4'h0,8'h00,32'h0,        32'h0,        32'h0,        0};

        rst = 1'b1; n_rst = 1'b1;
        en_a = 0; we_a = 0; be_a = 0; addr_a = 0; data_a = 0;
        en_b = 0; we_b = 0; be_b = 0; addr_b = 0; data_b = 0;
        n_en_a = 0; n_we_a = 0; n_be_a = 0; n_addr_a = 0; n_data_a = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset q_a", q_a, 32'h0);
        chk("reset q_b", q_b, 32'h0);
        chk("reset valid", {30'd0, valid_a, valid_b}, 32'h0);
        chk("reset collision", {31'd0, collision}, 32'h0);
        chk("reset busy", {31'd0, busy}, 32'h1);
        chk("nc reset busy", {31'd0, n_busy}, 32'h0);

        // INIT_CLEAR=0: usable at edge 0.
        n_rst = 1'b0;
        n_en_a = 1; n_we_a = 1; n_be_a = 4'hF; n_addr_a = 8'hFF; n_data_a = 32'hFFFFFFFF;
        @(posedge clk); #1;
        chk("nc busy", {31'd0, n_busy}, 32'h0);
        chk("nc write valid", {31'd0, n_valid_a}, 32'h1);
        chk("nc write q", n_q_a, 32'hFFFFFFFF);
        n_we_a = 0; n_data_a = 32'h0;
        @(posedge clk); #1;
        chk("nc read q", n_q_a, 32'hFFFFFFFF);
        chk("nc read valid", {31'd0, n_valid_a}, 32'h1);
        n_en_a = 0;

        // Initial clear sweep with port A requesting reads throughout.
        en_a = 1; we_a = 0; addr_a = 8'h00;
        rst = 1'b0;
        sweep("clear");

        for (int i = 0; i < 18; i++) step(vt[i], i);

        // Asynchronous reset from READY, then abort a sweep at edge 100.
        rst = 1'b1;
        #1;
        chk("async rst busy", {31'd0, busy}, 32'h1);
        chk("async rst q_a", q_a, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k <= 100; k++) begin
            @(posedge clk);
        end
        #1;
        chk("mid-clear busy", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst held busy", {31'd0, busy}, 32'h1);
        rst = 1'b0;
        sweep("restart");

        for (int i = 0; i < 3; i++) step(vp[i], 100 + i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
